// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and handshake control for the 8-entry x 32-bit FIFO.
// Drives the register file's one-hot write enables and the output mux read-select.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   INIT     | just out of reset, no request seen yet
//   NO_OP    | idle cycle, or write and read requested together
//   WRITE    | previous cycle's write accepted
//   WR_ERROR | previous cycle's write rejected, FIFO was full
//   READ     | previous cycle's read accepted
//   RD_ERROR | previous cycle's read rejected, FIFO was empty
module fifo_ctrl #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [DEPTH-1:0] we,
   output logic [PTR_W-1:0] rd_sel,
   output logic             rd_strobe,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] data_count,
   output logic             wr_ack,
   output logic             wr_err,
   output logic             rd_ack,
   output logic             rd_err
);

   typedef enum logic [2:0] {
      INIT,
      NO_OP,
      WRITE,
      WR_ERROR,
      READ,
      RD_ERROR
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             wr_only;
   logic             rd_only;
   logic             wr_go;
   logic             rd_go;

   assign full       = (count == CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign data_count = count;
   assign rd_sel     = head;

   assign wr_only = wr_en & ~rd_en;
   assign rd_only = rd_en & ~wr_en;
   assign wr_go   = wr_only & ~full;
   assign rd_go   = rd_only & ~empty;

   // Reset gates the enables so a write coinciding with reset never lands in the file.
   always_comb begin
      we = '0;
      if (wr_go && !reset) begin
         we[tail] = 1'b1;
      end
   end

   assign rd_strobe = rd_go & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr_only) begin
            state <= full ? WR_ERROR : WRITE;
         end else if (rd_only) begin
            state <= empty ? RD_ERROR : READ;
         end else begin
            state <= NO_OP;
         end

         if (wr_go) begin
            tail  <= tail + 1'b1;
            count <= count + 1'b1;
         end else if (rd_go) begin
            head  <= head + 1'b1;
            count <= count - 1'b1;
         end
      end
   end

   assign wr_ack = (state == WRITE);
   assign wr_err = (state == WR_ERROR);
   assign rd_ack = (state == READ);
   assign rd_err = (state == RD_ERROR);

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Control stage for the 8-entry x 32-bit FIFO. It sits directly upstream of the FIFO register file and drives that file's 8-bit one-hot write-enable bus. It also drives the read-select for the downstream output mux.
It tracks head/tail pointers and occupancy, arbitrates write and read requests through a state machine, and reports full/empty, acknowledges and errors.

Parameters:
DEPTH, 8, number of FIFO entries; fixed to 8 to match the register file's 8-bit enable bus.
PTR_W, 3, pointer width, log2(DEPTH).
CNT_W, 4, occupancy counter width, able to hold 0..DEPTH.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
wr_en  input  1  write request; data for the register file is presented in the same cycle.
rd_en  input  1  read request.
we  output  8  one-hot write enable to register file entries 0..7.
rd_sel  output  3  index of the entry to read (head); drives the output mux select.
rd_strobe  output  1  high in the cycle a read is accepted; downstream output register loads on this.
full  output  1  data_count == 8.
empty  output  1  data_count == 0.
data_count  output  4  current occupancy, 0..8.
wr_ack  output  1  registered: previous cycle's write was accepted.
wr_err  output  1  registered: previous cycle's write was rejected (FIFO full).
rd_ack  output  1  registered: previous cycle's read was accepted.
rd_err  output  1  registered: previous cycle's read was rejected (FIFO empty).

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Registered state:
  - head[2:0] and tail[2:0] pointers.
  - count[3:0].
  - FSM state: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR.
- Reset (reset=1 at a clock edge):
  - head=0, tail=0, count=0, state=INIT.
  - wr_ack=wr_err=rd_ack=rd_err=0.
  - Outputs: full=0, empty=1, data_count=0, rd_sel=0.
  - we=8'h00 and rd_strobe=0 combinationally whenever reset=1.
- Request decode, combinational each cycle:
  - wr_go = wr_en & ~rd_en & ~full.
  - rd_go = rd_en & ~wr_en & ~empty.
- Next-state, evaluated every cycle from any state including INIT:
  - wr_en & ~rd_en & full -> WR_ERROR.
  - wr_en & ~rd_en & ~full -> WRITE.
  - rd_en & ~wr_en & empty -> RD_ERROR.
  - rd_en & ~wr_en & ~empty -> READ.
  - Both requests high, or neither -> NO_OP.
  - Simultaneous wr_en & rd_en is rejected as NO_OP: no pointer or count change, no ack, no error.
- Write path:
  - we = one-hot(tail) when wr_go, else 8'h00. It is combinational, so the register file captures data on the same edge.
  - On that edge: tail <= tail+1 (mod 8, 7 wraps to 0) and count <= count+1.
- Read path:
  - rd_sel = head at all times.
  - rd_strobe = rd_go.
  - On that edge: head <= head+1 (mod 8) and count <= count-1.
- Status outputs:
  - wr_ack/wr_err/rd_ack/rd_err are Moore outputs of the registered state (WRITE/WR_ERROR/READ/RD_ERROR respectively). Each is high for exactly one cycle per accepted/rejected request cycle, one cycle after the request.
  - INIT and NO_OP drive all four low.
- full, empty and data_count are combinational from the registered count only.
- count never exceeds 8 or goes below 0; rejected requests leave all pointers and the count unchanged.
- Reset asserted mid-operation overrides any request in that cycle: no write enable is issued and all state clears at that edge.
- Latency: write data visible at the register file output 1 cycle after the wr_go edge; ack/err 1 cycle after the request.

Test Plan:
- Reset: hold reset 2 cycles -> empty=1, full=0, data_count=0, we=00, rd_sel=0, all ack/err=0.
- Fill: 8 consecutive wr_en cycles -> we = 01,02,04,...,80. wr_ack high the cycle after each. data_count reaches 8, full=1. A 9th wr_en -> we=00, wr_err=1 next cycle, count stays 8.
- Drain: 8 rd_en cycles -> rd_sel 0..7, rd_strobe high each cycle, rd_ack high each following cycle. Ends with empty=1. A 9th rd_en -> rd_err=1, rd_strobe=0, head unchanged.
- Wrap-around: write 5, read 5, write 6 -> we sequence for the last 6 writes is 20,40,80,01,02,04; data_count=6, rd_sel=5.
- Simultaneous: with count=3, assert wr_en=rd_en=1 for 2 cycles -> we=00, rd_strobe=0, count stays 3, no ack/err, state NO_OP.
- Reset mid-op: with count=4, assert reset together with wr_en -> we=00 that cycle, next cycle count=0, empty=1, tail=head=0.
